arbitro_teclado_display: RTL and testbench

- Time-multiplexes the shared keypad decoder and the 6-digit display between the `operacional` controller and the `setup` controller of the door lock.
- Sits between `decodificador_de_teclado` and both controllers.
- Owns `teclado_en` and the display bus.
- Inserts a guard window on every ownership change so that no keypress or stale display frame leaks to the new owner.

---
 rtl/arbitro_teclado_display.sv | 163 ++++++++++++++++
 tb/tb_arbitro_teclado_display.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_teclado_display.sv
// Shares the keypad decoder and 6-digit display between the operacional and setup controllers.
// Each ownership change runs a guard window: keypad disabled and display blanked.
module arbitro_teclado_display #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic [3:0]  BLANK_BCD    = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        setup_on,
  input  logic        data_setup_ok,
  input  logic        teclado_en_op,
  input  logic        display_en_op,
  input  logic [23:0] bcd_pac_op,
  input  logic        display_en_setup,
  input  logic [23:0] bcd_pac_setup,
  input  logic [3:0]  digitos_value,
  input  logic        digitos_valid,
  output logic        teclado_en,
  output logic [3:0]  digitos_value_op,
  output logic        digitos_valid_op,
  output logic [3:0]  digitos_value_setup,
  output logic        digitos_valid_setup,
  output logic        display_en,
  output logic [23:0] bcd_pac,
  output logic        dono
);

  typedef enum logic [1:0] {StOp, StGSetup, StSetup, StGOp} state_e;

  localparam logic [7:0] CntReload = 8'(GUARD_CYCLES - 1);

  state_e      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_bloq;

  logic        r_teclado_en, w_teclado_en;
  logic [3:0]  r_value_op, w_value_op;
  logic        r_valid_op, w_valid_op;
  logic [3:0]  r_value_setup, w_value_setup;
  logic        r_valid_setup, w_valid_setup;
  logic        r_display_en, w_display_en;
  logic [23:0] r_bcd_pac, w_bcd_pac;
  logic        r_dono, w_dono;
  logic        w_key;
  logic        w_leaving;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StOp;
      r_cnt   <= '0;
      r_bloq  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Blocks re-entry after a finished setup until setup_on has dropped at least once.
      if (!setup_on)          r_bloq <= 1'b0;
      else if (data_setup_ok) r_bloq <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StOp: begin
        if (setup_on && !r_bloq) begin
          w_state_next = StGSetup;
          w_cnt_next   = CntReload;
        end
      end
      StGSetup: begin
        if (!setup_on) begin
          w_state_next = StGOp;
          w_cnt_next   = CntReload;
        end else if (r_cnt == 8'd0) begin
          w_state_next = StSetup;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      StSetup: begin
        if (data_setup_ok || !setup_on) begin
          w_state_next = StGOp;
          w_cnt_next   = CntReload;
        end
      end
      StGOp: begin
        if (r_cnt == 8'd0) w_state_next = StOp;
        else               w_cnt_next   = r_cnt - 8'd1;
      end
      default: w_state_next = StOp;
    endcase
  end

  // A strobe counts only while the decoder was actually enabled; a leaving owner gets nothing.
  assign w_key     = digitos_valid && r_teclado_en;
  assign w_leaving = (w_state_next != r_state);

  always_comb begin
    w_teclado_en  = 1'b0;
    w_value_op    = r_value_op;
    w_valid_op    = 1'b0;
    w_value_setup = r_value_setup;
    w_valid_setup = 1'b0;
    w_display_en  = 1'b1;
    w_bcd_pac     = {6{BLANK_BCD}};
    w_dono        = 1'b0;
    unique case (r_state)
      StOp: begin
        w_teclado_en = teclado_en_op;
        w_display_en = display_en_op;
        w_bcd_pac    = bcd_pac_op;
        if (w_key && !w_leaving) begin
          w_valid_op = 1'b1;
          w_value_op = digitos_value;
        end
      end
      StSetup: begin
        w_teclado_en = 1'b1;
        w_display_en = display_en_setup;
        w_bcd_pac    = bcd_pac_setup;
        w_dono       = 1'b1;
        if (w_key && !w_leaving) begin
          w_valid_setup = 1'b1;
          w_value_setup = digitos_value;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_teclado_en  <= 1'b0;
      r_value_op    <= '0;
      r_valid_op    <= 1'b0;
      r_value_setup <= '0;
      r_valid_setup <= 1'b0;
      r_display_en  <= 1'b0;
      r_bcd_pac     <= '0;
      r_dono        <= 1'b0;
    end else begin
      r_teclado_en  <= w_teclado_en;
      r_value_op    <= w_value_op;
      r_valid_op    <= w_valid_op;
      r_value_setup <= w_value_setup;
      r_valid_setup <= w_valid_setup;
      r_display_en  <= w_display_en;
      r_bcd_pac     <= w_bcd_pac;
      r_dono        <= w_dono;
    end
  end

  assign teclado_en          = r_teclado_en;
  assign digitos_value_op    = r_value_op;
  assign digitos_valid_op    = r_valid_op;
  assign digitos_value_setup = r_value_setup;
  assign digitos_valid_setup = r_valid_setup;
  assign display_en          = r_display_en;
  assign bcd_pac             = r_bcd_pac;
  assign dono                = r_dono;

endmodule

// File: tb/tb_arbitro_teclado_display.sv
// Bench for arbitro_teclado_display: directed ownership scenarios plus random traffic,
// checked cycle by cycle against a guard-countdown reference model through a scoreboard queue.
module tb_arbitro_teclado_display;

  localparam int unsigned G = 4;

  logic        clk = 1'b0;
  logic        rst, setup_on, data_setup_ok, teclado_en_op, display_en_op, display_en_setup;
  logic        digitos_valid;
  logic [23:0] bcd_pac_op, bcd_pac_setup;
  logic [3:0]  digitos_value;
  logic        teclado_en, digitos_valid_op, digitos_valid_setup, display_en, dono;
  logic [3:0]  digitos_value_op, digitos_value_setup;
  logic [23:0] bcd_pac;

  arbitro_teclado_display #(.GUARD_CYCLES(G), .BLANK_BCD(4'hF)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .setup_on            (setup_on),
    .data_setup_ok       (data_setup_ok),
    .teclado_en_op       (teclado_en_op),
    .display_en_op       (display_en_op),
    .bcd_pac_op          (bcd_pac_op),
    .display_en_setup    (display_en_setup),
    .bcd_pac_setup       (bcd_pac_setup),
    .digitos_value       (digitos_value),
    .digitos_valid       (digitos_valid),
    .teclado_en          (teclado_en),
    .digitos_value_op    (digitos_value_op),
    .digitos_valid_op    (digitos_valid_op),
    .digitos_value_setup (digitos_value_setup),
    .digitos_valid_setup (digitos_valid_setup),
    .display_en          (display_en),
    .bcd_pac             (bcd_pac),
    .dono                (dono)
  );

  always #5 clk = ~clk;

  // Reference model: owner flag plus remaining guard cycles and guard direction.
  int         m_guard;
  bit         m_to_setup, m_in_setup, m_bloq, m_ten;
  logic [3:0] m_vop, m_vset;

  logic [36:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [36:0] model_step();
    logic        ten, vldop, vldset, den, own;
    logic [23:0] bcd;
    bit          key;
    if (rst) begin
      m_guard = 0; m_to_setup = 0; m_in_setup = 0; m_bloq = 0; m_ten = 0;
      m_vop = '0; m_vset = '0;
      return '0;
    end
    key    = digitos_valid && m_ten;
    vldop  = 1'b0;
    vldset = 1'b0;
    if (m_guard > 0) begin
      ten = 1'b0; den = 1'b1; bcd = 24'hFFFFFF; own = 1'b0;
      if (m_to_setup && !setup_on) begin
        m_to_setup = 0;
        m_guard    = G;
      end else begin
        m_guard--;
        if (m_guard == 0) m_in_setup = m_to_setup;
      end
    end else if (m_in_setup) begin
      ten = 1'b1; den = display_en_setup; bcd = bcd_pac_setup; own = 1'b1;
      if (data_setup_ok || !setup_on) begin
        m_guard    = G;
        m_to_setup = 0;
      end else if (key) begin
        vldset = 1'b1;
        m_vset = digitos_value;
      end
    end else begin
      ten = teclado_en_op; den = display_en_op; bcd = bcd_pac_op; own = 1'b0;
      if (setup_on && !m_bloq) begin
        m_guard    = G;
        m_to_setup = 1;
      end else if (key) begin
        vldop = 1'b1;
        m_vop = digitos_value;
      end
    end
    if (!setup_on)          m_bloq = 0;
    else if (data_setup_ok) m_bloq = 1;
    m_ten = ten;
    return {ten, m_vop, vldop, m_vset, vldset, den, bcd, own};
  endfunction

  logic [36:0] act;
  assign act = {teclado_en, digitos_value_op, digitos_valid_op, digitos_value_setup,
                digitos_valid_setup, display_en, bcd_pac, dono};

  // Monitor: every edge produces one registered output frame to compare.
  always @(posedge clk) begin
    logic [36:0] exp_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got=%h expected=%h (ten,vop,vldop,vset,vldset,den,bcd,dono)",
                 $time, act, exp_v);
      end
    end
  end

  // Watchdog: the stimulus must finish well before this bound.
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Inputs are set at the falling edge; the model sees exactly what the next rising edge sees.
  task automatic step();
    exp_q.push_back(model_step());
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit son, input bit ok, input bit dv,
                       input logic [3:0] k);
    rst = r; setup_on = son; data_setup_ok = ok; digitos_valid = dv; digitos_value = k;
    step();
  endtask

  initial begin
    bit son;
    teclado_en_op = 1'b1; display_en_op = 1'b1; display_en_setup = 1'b1;
    bcd_pac_op = 24'h000042; bcd_pac_setup = 24'h123456;
    // Reset, then a forwarded operacional key.
    repeat (2) drive(1, 0, 0, 0, 4'h0);
    checks++;
    if (act !== 37'd0) begin
      errors++;
      $display("FAIL reset state t=%0t got=%h expected all zero", $time, act);
    end
    repeat (2) drive(0, 0, 0, 0, 4'h0);
    drive(0, 0, 0, 1, 4'h7);
    drive(0, 0, 0, 0, 4'h0);
    // Guard toward setup with keys strobed inside it.
    drive(0, 1, 0, 0, 4'h0);
    drive(0, 1, 0, 1, 4'h3);
    drive(0, 1, 0, 0, 4'h0);
    drive(0, 1, 0, 1, 4'h5);
    repeat (4) drive(0, 1, 0, 0, 4'h0);
    // Setup key and frame.
    drive(0, 1, 0, 1, 4'h9);
    drive(0, 1, 0, 0, 4'h0);
    // Finished setup with setup_on held: no re-entry until it drops.
    drive(0, 1, 1, 0, 4'h0);
    repeat (10) drive(0, 1, 0, 0, 4'h0);
    drive(0, 0, 0, 0, 4'h0);
    repeat (8) drive(0, 1, 0, 0, 4'h0);
    // Abort the guard toward setup in its second cycle.
    repeat (7) drive(0, 0, 0, 0, 4'h0);
    repeat (2) drive(0, 1, 0, 0, 4'h0);
    repeat (8) drive(0, 0, 0, 1, 4'h2);
    // Reset in SETUP, then reset in G_OP.
    repeat (8) drive(0, 1, 0, 0, 4'h0);
    drive(1, 1, 0, 0, 4'h0);
    repeat (3) drive(0, 0, 0, 1, 4'h6);
    repeat (8) drive(0, 1, 0, 0, 4'h0);
    repeat (2) drive(0, 0, 0, 0, 4'h0);
    drive(1, 0, 0, 0, 4'h0);
    repeat (3) drive(0, 0, 0, 1, 4'hA);
    // Random traffic.
    son = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) son = ~son;
      teclado_en_op    = ($urandom_range(0, 3) != 0);
      display_en_op    = 1'($urandom);
      display_en_setup = 1'($urandom);
      bcd_pac_op       = 24'($urandom);
      bcd_pac_setup    = 24'($urandom);
      drive(($urandom_range(0, 149) == 0), son, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) == 0), 4'($urandom));
    end
    repeat (2) drive(0, 0, 0, 0, 4'h0);
    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
